// File: rtl/pll_reconfig_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pll_reconfig_ctrl_if
//  Purpose  : Control-side bundle for the PLL reconfiguration sequencer.
//             Carries the shadow-write port, the commit request and the
//             sequencer status flags between the register/control logic
//             (master) and the sequencer (slave).
//  Signals  : wr_en/wr_ch/wr_odiv/wr_duty/wr_phase  shadow write request
//             wr_err                                one-cycle reject pulse
//             commit                                start reconfiguration
//             busy/locked/done/fail/lock_lost       sequencer status
//             attempt                               current/last attempt index
//  Revision : 1.0 - initial release
// ============================================================================
interface pll_reconfig_ctrl_if;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [9:0]  wr_odiv;
    logic [9:0]  wr_duty;
    logic [12:0] wr_phase;
    logic        wr_err;
    logic        commit;
    logic        busy;
    logic        locked;
    logic        done;
    logic        fail;
    logic        lock_lost;
    logic [1:0]  attempt;

    // Register/control side
    modport master (
        output wr_en, wr_ch, wr_odiv, wr_duty, wr_phase, commit,
        input  wr_err, busy, locked, done, fail, lock_lost, attempt
    );

    // Sequencer side
    modport slave (
        input  wr_en, wr_ch, wr_odiv, wr_duty, wr_phase, commit,
        output wr_err, busy, locked, done, fail, lock_lost, attempt
    );
endinterface
`default_nettype wire

// File: rtl/pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pll_reconfig_ctrl
//  Purpose  : Sequencer for the PLL dynamic-divider interface. Holds a
//             5-channel shadow bank of output divider / duty / phase values.
//             A commit snapshots the shadow into a pending bank, pulses the
//             PLL reset while the pending bank is applied to dyn_*, then
//             waits for a qualified lock with timeout and bounded retries.
//             Runs on the free-running reference clock only.
//  Ports    : clk        reference clock
//             rst        asynchronous active-high reset
//             ctrl       pll_reconfig_ctrl_if.slave (write port, commit,
//                        busy/locked/done/fail/lock_lost/attempt status)
//             pll_lock   asynchronous lock indication from the PLL
//             pll_rst    PLL reset, active-high
//             dyn_odiv   {ch4..ch0} x 10 output dividers
//             dyn_duty   {ch4..ch0} x 10 duty (half-VCO cycles)
//             dyn_phase  {ch4..ch0} x 13 phase steps
//  Options  : PLL_AUTO_RELOCK_EN - when defined, loss of lock in LOCKED
//             restarts the reset/lock sequence with the current dyn_*
//             settings instead of parking in FAIL.
//  Revision : 1.0 - initial release
// ============================================================================
module pll_reconfig_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 3,
    parameter int ODIV_INIT    = 100,
    parameter int DUTY_INIT    = 100,
    parameter int PHASE_INIT   = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pll_reconfig_ctrl_if.slave  ctrl,
    input  wire logic           pll_lock,
    output logic                pll_rst,
    output logic [49:0]         dyn_odiv,
    output logic [49:0]         dyn_duty,
    output logic [64:0]         dyn_phase
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_num_ch    = 5;
    localparam int c_odiv_w    = 10;
    localparam int c_duty_w    = 10;
    localparam int c_phase_w   = 13;

    // Reset pulse shorter than two cycles is not meaningful for the PLL.
    localparam int c_rst_cyc   = (RST_CYCLES < 2) ? 2 : RST_CYCLES;
    localparam int c_lock_tmo  = (LOCK_TIMEOUT < 1) ? 1 : LOCK_TIMEOUT;
    localparam int c_cnt_max   = (c_lock_tmo > c_rst_cyc) ? c_lock_tmo : c_rst_cyc;
    localparam int c_cnt_w     = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0]   c_cnt_zero  = '0;
    localparam logic [c_cnt_w-1:0]   c_cnt_one   = {{(c_cnt_w-1){1'b0}}, 1'b1};
    localparam logic [c_cnt_w-1:0]   c_cnt_sat   = {c_cnt_w{1'b1}};
    localparam logic [c_cnt_w-1:0]   c_rst_tc    = c_cnt_w'(c_rst_cyc - 1);
    localparam logic [c_cnt_w-1:0]   c_lock_tc   = c_cnt_w'(c_lock_tmo - 1);
    localparam logic [1:0]           c_max_retry = 2'(MAX_RETRY);
    localparam logic [1:0]           c_qual_tc   = 2'd3;

    localparam logic [c_odiv_w-1:0]  c_odiv_init  = c_odiv_w'(ODIV_INIT);
    localparam logic [c_duty_w-1:0]  c_duty_init  = c_duty_w'(DUTY_INIT);
    localparam logic [c_phase_w-1:0] c_phase_init = c_phase_w'(PHASE_INIT);

    typedef enum logic [1:0] {
        S_PRST   = 2'd0,
        S_WLOCK  = 2'd1,
        S_LOCKED = 2'd2,
        S_FAIL   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Lock synchroniser: pll_lock is asynchronous to clk.
    // ------------------------------------------------------------------------
    logic r_lock_meta;
    logic r_lock_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Shadow write validation. Duty is in half-VCO cycles, so it must stay
    // strictly below twice the divider; the doubled divider needs 11 bits.
    // ------------------------------------------------------------------------
    logic [c_odiv_w:0] w_odiv_x2;
    logic              w_wr_bad;
    logic              w_wr_ok;

    always_comb begin
        w_odiv_x2 = {ctrl.wr_odiv, 1'b0};
        w_wr_bad  = (ctrl.wr_ch > 3'd4)
                 || (ctrl.wr_odiv == '0)
                 || (ctrl.wr_duty == '0)
                 || ({1'b0, ctrl.wr_duty} >= w_odiv_x2);
        w_wr_ok   = ctrl.wr_en && !w_wr_bad;
    end

    // ------------------------------------------------------------------------
    // Shadow bank. w_nx_* is the shadow including any write accepted this
    // cycle, so a commit in the same cycle captures the new value.
    // ------------------------------------------------------------------------
    logic [c_odiv_w-1:0]  r_sh_odiv  [c_num_ch];
    logic [c_duty_w-1:0]  r_sh_duty  [c_num_ch];
    logic [c_phase_w-1:0] r_sh_phase [c_num_ch];

    logic [c_odiv_w-1:0]  w_nx_odiv  [c_num_ch];
    logic [c_duty_w-1:0]  w_nx_duty  [c_num_ch];
    logic [c_phase_w-1:0] w_nx_phase [c_num_ch];

    always_comb begin
        for (int ch = 0; ch < c_num_ch; ch++) begin
            w_nx_odiv[ch]  = r_sh_odiv[ch];
            w_nx_duty[ch]  = r_sh_duty[ch];
            w_nx_phase[ch] = r_sh_phase[ch];
            if (w_wr_ok && (ctrl.wr_ch == 3'(ch))) begin
                w_nx_odiv[ch]  = ctrl.wr_odiv;
                w_nx_duty[ch]  = ctrl.wr_duty;
                w_nx_phase[ch] = ctrl.wr_phase;
            end
        end
    end

    logic r_wr_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < c_num_ch; ch++) begin
                r_sh_odiv[ch]  <= c_odiv_init;
                r_sh_duty[ch]  <= c_duty_init;
                r_sh_phase[ch] <= c_phase_init;
            end
            r_wr_err <= 1'b0;
        end else begin
            for (int ch = 0; ch < c_num_ch; ch++) begin
                r_sh_odiv[ch]  <= w_nx_odiv[ch];
                r_sh_duty[ch]  <= w_nx_duty[ch];
                r_sh_phase[ch] <= w_nx_phase[ch];
            end
            r_wr_err <= ctrl.wr_en && w_wr_bad;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;       // PRST length / WLOCK timeout
    logic [1:0]           r_qual;      // consecutive lock_s cycles seen
    logic [1:0]           r_attempt;
    logic                 r_pll_rst;
    logic                 r_busy;
    logic                 r_locked;
    logic                 r_done;
    logic                 r_fail;
    logic                 r_lock_lost;

    logic [c_odiv_w-1:0]  r_pd_odiv  [c_num_ch];
    logic [c_duty_w-1:0]  r_pd_duty  [c_num_ch];
    logic [c_phase_w-1:0] r_pd_phase [c_num_ch];

    logic [49:0]          r_dyn_odiv;
    logic [49:0]          r_dyn_duty;
    logic [64:0]          r_dyn_phase;

    logic                 w_commit_ok;

    // Commits arriving mid-sequence are dropped silently.
    assign w_commit_ok = ctrl.commit && ((r_state == S_LOCKED) || (r_state == S_FAIL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_PRST;
            r_cnt       <= c_cnt_zero;
            r_qual      <= 2'd0;
            r_attempt   <= 2'd0;
            r_pll_rst   <= 1'b1;
            r_busy      <= 1'b1;
            r_locked    <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_lock_lost <= 1'b0;
            for (int ch = 0; ch < c_num_ch; ch++) begin
                r_pd_odiv[ch]  <= c_odiv_init;
                r_pd_duty[ch]  <= c_duty_init;
                r_pd_phase[ch] <= c_phase_init;
            end
            r_dyn_odiv  <= {c_num_ch{c_odiv_init}};
            r_dyn_duty  <= {c_num_ch{c_duty_init}};
            r_dyn_phase <= {c_num_ch{c_phase_init}};
        end else begin
            r_done      <= 1'b0;
            r_lock_lost <= 1'b0;

            if (w_commit_ok) begin
                for (int ch = 0; ch < c_num_ch; ch++) begin
                    r_pd_odiv[ch]  <= w_nx_odiv[ch];
                    r_pd_duty[ch]  <= w_nx_duty[ch];
                    r_pd_phase[ch] <= w_nx_phase[ch];
                end
                r_attempt <= 2'd0;
                r_fail    <= 1'b0;
                r_locked  <= 1'b0;
                r_busy    <= 1'b1;
                r_pll_rst <= 1'b1;
                r_cnt     <= c_cnt_zero;
                r_state   <= S_PRST;
            end else begin
                case (r_state)
                    S_PRST: begin
                        // Settings change only while the PLL is held in reset.
                        if (r_cnt == c_cnt_zero) begin
                            for (int ch = 0; ch < c_num_ch; ch++) begin
                                r_dyn_odiv[ch*c_odiv_w +: c_odiv_w]    <= r_pd_odiv[ch];
                                r_dyn_duty[ch*c_duty_w +: c_duty_w]    <= r_pd_duty[ch];
                                r_dyn_phase[ch*c_phase_w +: c_phase_w] <= r_pd_phase[ch];
                            end
                        end
                        if (r_cnt == c_rst_tc) begin
                            r_pll_rst <= 1'b0;
                            r_cnt     <= c_cnt_zero;
                            r_qual    <= 2'd0;
                            r_state   <= S_WLOCK;
                        end else if (r_cnt != c_cnt_sat) begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end

                    S_WLOCK: begin
                        if (r_lock_s && (r_qual == c_qual_tc)) begin
                            r_done   <= 1'b1;
                            r_locked <= 1'b1;
                            r_busy   <= 1'b0;
                            r_cnt    <= c_cnt_zero;
                            r_state  <= S_LOCKED;
                        end else begin
                            // A lock glitch restarts qualification only;
                            // the timeout keeps running.
                            r_qual <= r_lock_s ? (r_qual + 2'd1) : 2'd0;
                            if (r_cnt == c_lock_tc) begin
                                r_cnt <= c_cnt_zero;
                                if (r_attempt < c_max_retry) begin
                                    r_attempt <= r_attempt + 2'd1;
                                    r_pll_rst <= 1'b1;
                                    r_state   <= S_PRST;
                                end else begin
                                    r_fail  <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= S_FAIL;
                                end
                            end else if (r_cnt != c_cnt_sat) begin
                                r_cnt <= r_cnt + c_cnt_one;
                            end
                        end
                    end

                    S_LOCKED: begin
                        if (!r_lock_s) begin
                            r_lock_lost <= 1'b1;
                            r_locked    <= 1'b0;
`ifdef PLL_AUTO_RELOCK_EN
                            // Pending bank already equals dyn_*, so the
                            // restarted sequence reapplies the same settings.
                            r_attempt <= 2'd0;
                            r_pll_rst <= 1'b1;
                            r_busy    <= 1'b1;
                            r_cnt     <= c_cnt_zero;
                            r_state   <= S_PRST;
`else
                            r_fail  <= 1'b1;
                            r_state <= S_FAIL;
`endif
                        end
                    end

                    S_FAIL: begin
                        r_pll_rst <= 1'b0;
                        r_busy    <= 1'b0;
                    end

                    default: begin
                        r_state <= S_FAIL;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pll_rst        = r_pll_rst;
    assign dyn_odiv       = r_dyn_odiv;
    assign dyn_duty       = r_dyn_duty;
    assign dyn_phase      = r_dyn_phase;

    assign ctrl.wr_err    = r_wr_err;
    assign ctrl.busy      = r_busy;
    assign ctrl.locked    = r_locked;
    assign ctrl.done      = r_done;
    assign ctrl.fail      = r_fail;
    assign ctrl.lock_lost = r_lock_lost;
    assign ctrl.attempt   = r_attempt;

endmodule
`default_nettype wire
